md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched.sv | 140 ++++++++++++++
 tb/tb_md_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the E stage.
// Accepts mult/multu/div/divu/mthi/mtlo. It computes the pending 64-bit
// {hi,lo} result at accept time. It then holds busy for a fixed latency and
// commits to HI/LO on the final RUN edge. mthi/mtlo write HI/LO directly.
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        op_valid,
  input  logic        exc_int,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] pending;
  logic        pend_ok;     // pending result is to be written at the commit edge

  logic        accept;
  logic        run_op;
  logic [63:0] result;
  logic        result_ok;
  logic [63:0] ext_s1, ext_s2, prod_s, prod_u;
  logic [31:0] divisor;
  logic signed [31:0] sq, sr;
  logic [31:0] uq, ur;

  // Decode the opcode and form the result of the op being offered this cycle.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    accept    = 1'b0;
    run_op    = 1'b0;
    result    = 64'd0;
    result_ok = 1'b1;
    sq        = '0;
    sr        = '0;
    uq        = '0;
    ur        = '0;

    run_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    accept = op_valid && !exc_int && (state == IDLE) &&
             (run_op || (op == OP_MTHI) || (op == OP_MTLO));

    // The low 64 bits of a two's-complement product match the signed product.
    // So sign-extended operands with an unsigned multiply give the signed result.
    ext_s1  = {{32{d1[31]}}, d1};
    ext_s2  = {{32{d2[31]}}, d2};
    prod_s  = ext_s1 * ext_s2;
    prod_u  = {32'd0, d1} * {32'd0, d2};

    // A zero divisor commits nothing, so substitute 1 to keep the divider defined.
    divisor = (d2 == 32'd0) ? 32'd1 : d2;
    if (d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) begin
      sq = 32'sh8000_0000;
      sr = 32'sd0;
    end else begin
      sq = $signed(d1) / $signed(divisor);
      sr = $signed(d1) % $signed(divisor);
    end
    uq = d1 / divisor;
    ur = d1 % divisor;

    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   begin result = {sr, sq}; result_ok = (d2 != 32'd0); end
      OP_DIVU:  begin result = {ur, uq}; result_ok = (d2 != 32'd0); end
      default:  result = 64'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a started op enters RUN, and the last count returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: start and stall are gated by reset so they read 0 during reset.
  always_comb begin
    start = reset && accept && run_op;
    busy  = (state == RUN);
    stall = reset && md_use && (start || busy);
  end

  // Datapath: counter, pending result, and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: pending is cleared on reset so an aborted op can never commit later.
    if (!reset) begin
      cnt     <= 4'd0;
      pending <= 64'd0;
      pend_ok <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == RUN) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pend_ok) begin
        hi <= pending[63:32];
        lo <= pending[31:0];
      end
    end else if (accept) begin
      if (run_op) begin
        pending <= result;
        pend_ok <= result_ok;
        cnt     <= (op == OP_DIV || op == OP_DIVU) ? 4'd10 : 4'd5;
      end else if (op == OP_MTHI) begin
        hi <= d1;
      end else begin
        lo <= d1;
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed-vector bench for md_sched with hand-computed results.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic        op_valid;
  logic        exc_int;
  logic [31:0] d1, d2;
  logic        md_use;
  logic        start, busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_sched dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .exc_int(exc_int),
    .d1(d1), .d2(d2), .md_use(md_use), .start(start), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    op = 3'd0; op_valid = 1'b0; exc_int = 1'b0; d1 = '0; d2 = '0;
  endtask

  // Offer an op at a negedge and check start combinationally. Then count the
  // busy cycles over a bounded window, with stall checked against md_use & busy.
  // If inject is set, a mult is offered at busy cycle 2 and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic use_md, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic inject);
    int n = 0;
    @(negedge clk);
    op = o; op_valid = 1'b1; d1 = a; d2 = b; md_use = use_md;
    #1;
    check({tag, " start"}, start, 1);
    check({tag, " stall@start"}, stall, use_md);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      idle_inputs();
      if (inject && i == 1) begin
        op = 3'd1; op_valid = 1'b1; d1 = 32'd3; d2 = 32'd3;
      end
      #1;
      if (inject && i == 1) check({tag, " ignored start"}, start, 0);
      if (busy) n++;
      if (use_md) check($sformatf("%s stall c%0d", tag, i), stall, busy);
    end
    md_use = 1'b0;
    check({tag, " busy cycles"}, n, exp_busy);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    idle_inputs();
    md_use = 1'b1;
    reset = 1'b0;
    op = 3'd1; op_valid = 1'b1; d1 = 32'd5; d2 = 32'd5;
    #12;
    check("rst start", start, 0);
    check("rst busy", busy, 0);
    check("rst stall", stall, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    @(negedge clk);
    idle_inputs();
    md_use = 1'b0;
    reset = 1'b1;

    // Signed and unsigned multiply; the first case also checks stall and the ignored reissue.
    run_op("mult",  3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    // Signed divide, then divide by zero leaves HI/LO untouched.
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0", 3'd4, 32'd7, 32'd0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu",  3'd4, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14, 1'b0);

    // An exception in the same cycle blocks acceptance.
    @(negedge clk);
    op = 3'd3; op_valid = 1'b1; exc_int = 1'b1; d1 = 32'd50; d2 = 32'd5;
    #1;
    check("exc start", start, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("exc busy", busy, 0);
    check("exc hi", hi, 32'd2);
    check("exc lo", lo, 32'd14);

    // mtlo and mthi write directly and do not start.
    @(negedge clk);
    op = 3'd6; op_valid = 1'b1; d1 = 32'h1234_5678;
    #1;
    check("mtlo start", start, 0);
    @(negedge clk);
    op = 3'd5; op_valid = 1'b1; d1 = 32'hCAFE_0001;
    #1;
    check("mtlo lo", lo, 32'h1234_5678);
    check("mtlo busy", busy, 0);
    @(negedge clk);
    op = 3'd7; op_valid = 1'b1; d1 = 32'd9;
    #1;
    check("mthi hi", hi, 32'hCAFE_0001);
    check("op7 start", start, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("op7 busy", busy, 0);
    check("op7 hi", hi, 32'hCAFE_0001);
    check("op7 lo", lo, 32'h1234_5678);

    // A reset at busy cycle 3 of a div aborts it and clears HI/LO.
    @(negedge clk);
    op = 3'd3; op_valid = 1'b1; d1 = 32'd40; d2 = 32'd4; md_use = 1'b1;
    #1;
    check("rdiv start", start, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    #1;
    check("rdiv busy3", busy, 1);
    reset = 1'b0;
    #1;
    check("rdiv busy", busy, 0);
    check("rdiv stall", stall, 0);
    check("rdiv hi", hi, 0);
    check("rdiv lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    md_use = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    #1;
    check("rdiv late busy", busy, 0);
    check("rdiv late hi", hi, 0);
    check("rdiv late lo", lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
